// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, DATA_BITS LSB-first,
// optional parity, 1 or 2 stop bits) with a four-phase Send/Sent handshake.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_param #(
  parameter int unsigned BAUD_DIV  = 5208,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Send,
  input  logic [DATA_BITS-1:0] Din,
`ifdef UART_TX_BREAK_EN
  input  logic                 Break,
`endif
  output logic                 Sent,
  output logic                 Busy,
  output logic                 Sout
);

  localparam int unsigned TW = $clog2(BAUD_DIV);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  // Reject out-of-range configurations at elaboration
  if (BAUD_DIV < 2 || BAUD_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
    $error("uart_tx_param: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    ACK
`ifdef UART_TX_BREAK_EN
    , BRK
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 sout_q, sout_d;
  logic                 tick;
  logic [TW-1:0]        timer_step;
`ifdef UART_TX_BREAK_EN
  logic                 hold_q, hold_d;
`endif

  // Baud tick and free-running timer step (wraps at BAUD_DIV-1)
  assign tick       = (timer_q == TW'(BAUD_DIV - 1));
  assign timer_step = tick ? '0 : timer_q + TW'(1);

  // Next-state, datapath and next line level
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    sout_d    = 1'b1;
`ifdef UART_TX_BREAK_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_cnt_d = '0;
`ifdef UART_TX_BREAK_EN
        if (Break) begin
          state_d = BRK;
          hold_d  = 1'b0;
        end else
`endif
        if (Send) begin
          state_d = START;
          shift_d = Din;
          // Parity is fixed at capture since the shift register is consumed
          par_d   = (PARITY == 2) ? ^Din : ~^Din;
        end
      end
      START: begin
        sout_d  = 1'b0;
        timer_d = timer_step;
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        sout_d  = shift_q[0];
        timer_d = timer_step;
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PAR: begin
        sout_d  = par_q;
        timer_d = timer_step;
        if (tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        timer_d = timer_step;
        if (tick) begin
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            state_d   = ACK;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ACK: begin
        timer_d = '0;
        if (!Send) state_d = IDLE;
      end
`ifdef UART_TX_BREAK_EN
      BRK: begin
        // Line low until Break falls, then one full idle bit before IDLE
        sout_d = hold_q;
        if (!Break) hold_d = 1'b1;
        if (hold_q) begin
          timer_d = timer_step;
          if (tick) begin
            state_d = IDLE;
            hold_d  = 1'b0;
          end
        end else begin
          timer_d = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      sout_q    <= 1'b1;
`ifdef UART_TX_BREAK_EN
      hold_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      sout_q    <= sout_d;
`ifdef UART_TX_BREAK_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign Sent = (state_q == ACK);
  assign Busy = (state_q != IDLE);
  assign Sout = sout_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8O1, 7E2 and 8N1 instances at BAUD_DIV=16.
module tb_uart_tx_param;

  logic       clk;
  logic       reset;
  logic       brk;
  logic       send_a, send_b, send_c;
  logic [7:0] din_a, din_c;
  logic [6:0] din_b;
  logic       sent_a, busy_a, sout_a;
  logic       sent_b, busy_b, sout_b;
  logic       sent_c, busy_c, sout_c;
  int         checks;
  int         errors;

  uart_tx_param #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .Reset(reset), .Send(send_a), .Din(din_a),
`ifdef UART_TX_BREAK_EN
    .Break(brk),
`endif
    .Sent(sent_a), .Busy(busy_a), .Sout(sout_a));

  uart_tx_param #(.BAUD_DIV(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .Reset(reset), .Send(send_b), .Din(din_b),
`ifdef UART_TX_BREAK_EN
    .Break(1'b0),
`endif
    .Sent(sent_b), .Busy(busy_b), .Sout(sout_b));

  uart_tx_param #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .Reset(reset), .Send(send_c), .Din(din_c),
`ifdef UART_TX_BREAK_EN
    .Break(1'b0),
`endif
    .Sent(sent_c), .Busy(busy_c), .Sout(sout_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs driven 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; send_a = 1'b1; send_b = 1'b1; send_c = 1'b1;
    step(); step();
    checks++; if (sout_a !== 1'b1 || busy_a !== 1'b0 || sent_a !== 1'b0) begin
      errors++; $display("FAIL reset_8o1: sout/busy/sent=%b%b%b want 100", sout_a, busy_a, sent_a); end
    checks++; if (sout_b !== 1'b1 || busy_b !== 1'b0 || sent_b !== 1'b0) begin
      errors++; $display("FAIL reset_7e2: sout/busy/sent=%b%b%b want 100", sout_b, busy_b, sent_b); end
    checks++; if (sout_c !== 1'b1 || busy_c !== 1'b0 || sent_c !== 1'b0) begin
      errors++; $display("FAIL reset_8n1: sout/busy/sent=%b%b%b want 100", sout_c, busy_c, sent_c); end
    send_a = 1'b0; send_b = 1'b0; send_c = 1'b0;
    reset = 1'b0;
    step();
  endtask

  // 8O1 0xA5: 0,1,0,1,0,0,1,0,1,1,1 then Sent at 176 cycles
  task automatic test_8o1();
    logic [10:0] exp;
    exp = 11'b111_0100_1010;
    din_a = 8'hA5; send_a = 1'b1;
    step();
    checks++; if (busy_a !== 1'b1 || sout_a !== 1'b1) begin
      errors++; $display("FAIL 8o1_accept: busy=%b sout=%b want busy=1 sout=1", busy_a, sout_a); end
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 16; c++) begin
        step();
        checks++; if (sout_a !== exp[b]) begin
          errors++; $display("FAIL 8o1_bit%0d_cyc%0d: sout=%b want %b", b, c, sout_a, exp[b]); end
        checks++; if (sent_a !== ((b == 10) && (c == 15))) begin
          errors++; $display("FAIL 8o1_sent_b%0d_c%0d: sent=%b want %b", b, c, sent_a, (b == 10) && (c == 15)); end
      end
    end
    send_a = 1'b0;
    step();
    checks++; if (sent_a !== 1'b0 || busy_a !== 1'b0 || sout_a !== 1'b1) begin
      errors++; $display("FAIL 8o1_release: sent/busy/sout=%b%b%b want 001", sent_a, busy_a, sout_a); end
    step();
  endtask

  // 7E2 0x41: parity 0, two stop bits, 11 bit periods
  task automatic test_7e2();
    logic [10:0] exp;
    exp = 11'b110_1000_0010;
    din_b = 7'h41; send_b = 1'b1;
    step();
    checks++; if (busy_b !== 1'b1) begin
      errors++; $display("FAIL 7e2_accept: busy=%b want 1", busy_b); end
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 16; c++) begin
        step();
        checks++; if (sout_b !== exp[b]) begin
          errors++; $display("FAIL 7e2_bit%0d_cyc%0d: sout=%b want %b", b, c, sout_b, exp[b]); end
        checks++; if (sent_b !== ((b == 10) && (c == 15))) begin
          errors++; $display("FAIL 7e2_sent_b%0d_c%0d: sent=%b want %b", b, c, sent_b, (b == 10) && (c == 15)); end
      end
    end
    send_b = 1'b0;
    step();
    checks++; if (sent_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL 7e2_release: sent=%b busy=%b want 0 0", sent_b, busy_b); end
    step();
  endtask

  // 8N1 0x3C with Din changed to 0xFF after capture; 10 bit periods
  task automatic test_no_parity();
    logic [9:0] exp;
    exp = 10'b10_0111_1000;
    din_c = 8'h3C; send_c = 1'b1;
    step();
    din_c = 8'hFF;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 16; c++) begin
        step();
        checks++; if (sout_c !== exp[b]) begin
          errors++; $display("FAIL 8n1_bit%0d_cyc%0d: sout=%b want %b", b, c, sout_c, exp[b]); end
        checks++; if (sent_c !== ((b == 9) && (c == 15))) begin
          errors++; $display("FAIL 8n1_sent_b%0d_c%0d: sent=%b want %b", b, c, sent_c, (b == 9) && (c == 15)); end
      end
    end
    send_c = 1'b0;
    step(); step();
  endtask

  // Reset during data bit 3, then a full 0x5A frame
  task automatic test_reset_mid_frame();
    logic [10:0] exp;
    exp = 11'b110_1011_0100;
    din_a = 8'hA5; send_a = 1'b1;
    step();
    for (int i = 0; i < 70; i++) step();
    checks++; if (sout_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: sout=%b busy=%b want 0 1", sout_a, busy_a); end
    reset = 1'b1; send_a = 1'b0;
    step();
    checks++; if (sout_a !== 1'b1 || busy_a !== 1'b0 || sent_a !== 1'b0) begin
      errors++; $display("FAIL midrst_post: sout/busy/sent=%b%b%b want 100", sout_a, busy_a, sent_a); end
    reset = 1'b0;
    step();
    din_a = 8'h5A; send_a = 1'b1;
    step();
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < 16; c++) begin
        step();
        checks++; if (sout_a !== exp[b]) begin
          errors++; $display("FAIL midrst_frame_bit%0d_cyc%0d: sout=%b want %b", b, c, sout_a, exp[b]); end
      end
    end
    checks++; if (sent_a !== 1'b1) begin
      errors++; $display("FAIL midrst_sent: sent=%b want 1", sent_a); end
    send_a = 1'b0;
    step(); step();
  endtask

  // Send held through ACK sends nothing; low for 1 cycle then high restarts
  task automatic test_handshake();
    din_a = 8'h00; send_a = 1'b1;
    step();
    for (int i = 0; i < 176; i++) step();
    checks++; if (sent_a !== 1'b1) begin
      errors++; $display("FAIL hs_sent: sent=%b want 1", sent_a); end
    for (int i = 0; i < 30; i++) begin
      step();
      checks++; if (sout_a !== 1'b1 || sent_a !== 1'b1 || busy_a !== 1'b1) begin
        errors++; $display("FAIL hs_hold_%0d: sout/sent/busy=%b%b%b want 111", i, sout_a, sent_a, busy_a); end
    end
    send_a = 1'b0;
    step();
    checks++; if (sent_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL hs_release: sent=%b busy=%b want 0 0", sent_a, busy_a); end
    send_a = 1'b1;
    step();
    checks++; if (busy_a !== 1'b1 || sout_a !== 1'b1) begin
      errors++; $display("FAIL hs_restart_e1: busy=%b sout=%b want 1 1", busy_a, sout_a); end
    step();
    checks++; if (sout_a !== 1'b0) begin
      errors++; $display("FAIL hs_restart_e2: sout=%b want 0", sout_a); end
    reset = 1'b1; send_a = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

`ifdef UART_TX_BREAK_EN
  // Break for 100 cycles with Send high, one idle bit, then Send accepted
  task automatic test_break();
    brk = 1'b1; send_a = 1'b1;
    step();
    checks++; if (busy_a !== 1'b1) begin
      errors++; $display("FAIL brk_enter: busy=%b want 1", busy_a); end
    for (int i = 1; i <= 100; i++) begin
      step();
      checks++; if (sout_a !== 1'b0 || busy_a !== 1'b1) begin
        errors++; $display("FAIL brk_low_%0d: sout=%b busy=%b want 0 1", i, sout_a, busy_a); end
      if (i == 99) brk = 1'b0;
    end
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++; if (sout_a !== 1'b1 || busy_a !== (i < 16)) begin
        errors++; $display("FAIL brk_hold_%0d: sout=%b busy=%b want 1 %b", i, sout_a, busy_a, i < 16); end
    end
    step();
    checks++; if (busy_a !== 1'b1) begin
      errors++; $display("FAIL brk_send_accept: busy=%b want 1", busy_a); end
    step();
    checks++; if (sout_a !== 1'b0) begin
      errors++; $display("FAIL brk_send_start: sout=%b want 0", sout_a); end
    reset = 1'b1; send_a = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; brk = 1'b0;
    send_a = 1'b0; send_b = 1'b0; send_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    test_reset();
    test_8o1();
    test_7e2();
    test_no_parity();
    test_reset_mid_frame();
    test_handshake();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter; next generation of the fixed 8-bit, odd-parity, 1-stop transmitter. Baud divisor, data width, parity mode and stop-bit count are set per instance. The data word is captured at the start of the frame, so the source may change `Din` mid-frame. The block sits between the application-side Send/Sent handshake and the board TX pin.

## Interface

- `BAUD_DIV`, 5208: clock cycles per serial bit; legal range 2..65535.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY`, 1: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.

- `clk` input 1: system clock; all logic on the rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `Send` input 1: transmit request; four-phase handshake with `Sent`.
- `Din` input `DATA_BITS`: data word; captured on the cycle the request is accepted.
- `Break` input 1: line-break request. Present only with `UART_TX_BREAK_EN`.
- `Sent` output 1: frame complete; held high until `Send` falls.
- `Busy` output 1: high whenever the state is not IDLE.
- `Sout` output 1: registered serial line; idles high.

## Operation

- **States:** IDLE, START, DATA, PAR, STOP, ACK, plus BRK when `UART_TX_BREAK_EN` is defined.
- **IDLE:**
  - Baud timer held at 0 and bit counter held at 0.
  - With `Send`=1, the state moves to START and `Din` is latched into the shift register.
- **START:** start bit (0) for one bit period, then DATA.
- **DATA:**
  - Shift-register bit 0 is sent first (LSB first), then the register shifts right once per bit period.
  - After `DATA_BITS` periods: go to PAR if `PARITY`≠0, otherwise go to STOP.
- **PAR:**
  - Sends XNOR-reduce of the latched word for odd parity, XOR-reduce for even parity.
  - Lasts one bit period.
- **STOP:** line held at 1 for `STOP_BITS` periods, then ACK.
- **ACK:**
  - `Sent`=1.
  - Stays in ACK while `Send`=1 and returns to IDLE when `Send`=0.
  - A new frame needs `Send` to go low and then high again.
- **Baud timer:**
  - Counts 0..`BAUD_DIV`-1; `tick` fires when the count equals `BAUD_DIV`-1, then the count wraps to 0.
  - Width is clog2(`BAUD_DIV`).
  - Cleared in IDLE and ACK.
- **Bit counter:**
  - Width clog2(`DATA_BITS`+1).
  - Cleared on entry to DATA and to STOP.
  - Incremented on each `tick` inside those states.
- **Frame length:** (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) × `BAUD_DIV` cycles.
- **Boundary conditions:**
  - Changes on `Send` or `Din` after acceptance are ignored until ACK.
  - `Reset` mid-frame: state goes to IDLE at the next edge and `Sout` goes to 1 at that same edge. The frame is truncated, and `Sent` is not asserted.
  - `Reset` has priority over every other input.
  - Illegal parameter values are rejected by an elaboration-time `$error`.

## Timing

- **Reset values:** `Sout`=1, `Sent`=0, `Busy`=0, state IDLE, timer 0.
- **Frame start:**
  - `Send` is sampled high in IDLE at edge k.
  - State becomes START and `Busy`=1 at edge k.
  - `Sout`=0 from edge k+1, because `Sout` is registered from the current state and lags the state by one cycle.
- Each bit level on `Sout` is held for exactly `BAUD_DIV` cycles.
- **Frame end:**
  - `Sent` rises at the edge where the last stop-bit `tick` moves the state to ACK.
  - `Sent` is combinational from the state; `Sout` stays 1.
- **Release:** `Send` sampled low in ACK at edge m gives IDLE at edge m, `Sent`=0 and `Busy`=0.
- **Back-to-back frames:**
  - Minimum gap between frames is 1 cycle of IDLE.
  - The earliest new START is one edge after IDLE.

## Configuration

- **Macro:** `UART_TX_BREAK_EN`.
- **When defined:**
  - The `Break` port exists.
  - `Break`=1 sampled in IDLE moves the state to BRK, with priority over `Send`.
  - In BRK, `Sout`=0 and `Busy`=1 for as long as `Break`=1.
  - After `Break` falls, the line is held at 1 for one full bit period, then the state returns to IDLE.
  - `Send` is ignored while in BRK.
  - `Break` asserted mid-frame is ignored until IDLE.
- **When not defined:**
  - No `Break` port.
  - There is no BRK state and the state encoding excludes it.

## Test plan

- **8O1 frame** (`BAUD_DIV`=16, defaults otherwise), `Din`=8'hA5, `Send` pulse held:
  - `Sout` reads 0,1,0,1,0,0,1,0,1,1,1, each level for 16 cycles.
  - `Sent` high at cycle 176 after acceptance and stays high until `Send` drops.
- **7E2** (`DATA_BITS`=7, `PARITY`=2, `STOP_BITS`=2), `Din`=7'h41:
  - Parity bit = 0.
  - Two stop periods.
  - Total frame 11×`BAUD_DIV` cycles.
- **No parity** (`PARITY`=0), `Din` changed to 8'hFF one cycle after acceptance:
  - Transmitted bits still match the originally latched 8'h3C.
  - No parity slot in the frame.
- **Reset mid-frame** during data bit 3:
  - `Sout`=1, `Busy`=0, `Sent`=0 on the next edge.
  - A subsequent `Send` produces a complete, correct frame.
- **Handshake:**
  - `Send` held high through ACK: no second frame is sent.
  - Deassert `Send` then reassert after 1 cycle: second START begins `Sout`=0 two edges after reassertion.
- **`UART_TX_BREAK_EN`:**
  - `Break` high for 100 cycles with `Send` also high: `Sout`=0 for the full 100 cycles.
  - Then `Sout`=1 for 16 cycles, then IDLE.
  - After that, a new `Send` is accepted.
